// File: rtl/tx_sched_pkg.sv
// Shared types and widths for the TX frame scheduler.
// Optional statistics are enabled with TX_SCHED_STATS_EN.
package tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_PAD,
        ST_GAP
    } state_t;

    localparam int CNT_W = $clog2(4096);
    localparam int GAP_W = $clog2(256);

endpackage

// File: rtl/tx_sched_if.sv
// Requester and BCH-side bit streams of the TX frame scheduler.
// Master is the scheduler; slave is the surrounding TX path.
interface tx_sched_if;

    logic req0_valid;
    logic req0_data;
    logic req0_last;
    logic req0_ready;
    logic req1_valid;
    logic req1_data;
    logic req1_last;
    logic req1_ready;
    logic out_valid;
    logic out_data;
    logic out_ready;

    modport master (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        output req0_ready, req1_ready,
        output out_valid, out_data,
        input  out_ready
    );

    modport slave (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        input  req0_ready, req1_ready,
        input  out_valid, out_data,
        output out_ready
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter with one-hot grant.
// last=1 means req1 owned the previous frame.
module rr_arbiter_2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    input  logic       en,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req0 && (!req1 || last)) begin
                grant = 2'b01;
            end else if (req1) begin
                grant = 2'b10;
            end
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Frames two bit requesters into fixed-size BCH input frames.
// Define TX_SCHED_STATS_EN to add per-requester frame/pad counters.
module tx_frame_scheduler
    import tx_sched_pkg::*;
#(
    parameter int FRAME_BITS = 64,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    tx_sched_if.master  bus,
    output logic [1:0]  grant,
    output logic        busy
`ifdef TX_SCHED_STATS_EN
    ,
    output logic [15:0] frames0_cnt,
    output logic [15:0] frames1_cnt,
    output logic [15:0] pad_cnt
`endif
);

    localparam logic [CNT_W-1:0] FB_LAST =
        CNT_W'(FRAME_BITS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [1:0]       grant_q;
    logic             last_q;
    logic [1:0]       arb_grant;
    logic             sel_valid;
    logic             sel_data;
    logic             sel_last;
    logic             hs;
    logic             frame_done;

    rr_arbiter_2 u_arb (
        .req0  (bus.req0_valid),
        .req1  (bus.req1_valid),
        .last  (last_q),
        .en    (state == ST_IDLE),
        .grant (arb_grant)
    );

    assign sel_valid = grant_q[1] ? bus.req1_valid
                                  : bus.req0_valid;
    assign sel_data  = grant_q[1] ? bus.req1_data
                                  : bus.req0_data;
    assign sel_last  = grant_q[1] ? bus.req1_last
                                  : bus.req0_last;

    // Reset forces every output low even before the state settles
    always_comb begin
        bus.out_valid  = 1'b0;
        bus.out_data   = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        if (!rst) begin
            unique case (state)
                ST_SEND: begin
                    bus.out_valid  = sel_valid;
                    bus.out_data   = sel_data;
                    bus.req0_ready = grant_q[0] & bus.out_ready;
                    bus.req1_ready = grant_q[1] & bus.out_ready;
                end
                ST_PAD:  bus.out_valid = 1'b1;
                default: ;
            endcase
        end
    end

    assign hs         = bus.out_valid && bus.out_ready;
    assign frame_done = hs && (cnt == FB_LAST);
    assign grant      = rst ? 2'b00 : grant_q;
    assign busy       = !rst && (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            gap_cnt <= '0;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|arb_grant) begin
                        state   <= ST_SEND;
                        grant_q <= arb_grant;
                        last_q  <= arb_grant[1];
                        cnt     <= '0;
                    end
                end
                ST_SEND, ST_PAD: begin
                    if (frame_done) begin
                        cnt     <= '0;
                        gap_cnt <= '0;
                        grant_q <= 2'b00;
                        state   <= (GAP_CYCLES == 0) ? ST_IDLE
                                                     : ST_GAP;
                    end else if (hs) begin
                        cnt <= cnt + 1'b1;
                        if (state == ST_SEND && sel_last) begin
                            state <= ST_PAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef TX_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frames0_cnt <= '0;
            frames1_cnt <= '0;
            pad_cnt     <= '0;
        end else if (frame_done) begin
            if (grant_q[0]) frames0_cnt <= frames0_cnt + 1'b1;
            if (grant_q[1]) frames1_cnt <= frames1_cnt + 1'b1;
            if (state == ST_PAD) pad_cnt <= pad_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler: two instances (GAP 2 and GAP 0) share
// stimulus and are each checked every cycle against a frame-level model.
module tb_tx_frame_scheduler;

    localparam int FB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic r0v = 0, r0d = 0, r0l = 0;
    logic r1v = 0, r1d = 0, r1l = 0;
    logic ordy = 0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tx_sched_if ia ();
    tx_sched_if ib ();

    assign ia.req0_valid = r0v;
    assign ia.req0_data  = r0d;
    assign ia.req0_last  = r0l;
    assign ia.req1_valid = r1v;
    assign ia.req1_data  = r1d;
    assign ia.req1_last  = r1l;
    assign ia.out_ready  = ordy;
    assign ib.req0_valid = r0v;
    assign ib.req0_data  = r0d;
    assign ib.req0_last  = r0l;
    assign ib.req1_valid = r1v;
    assign ib.req1_data  = r1d;
    assign ib.req1_last  = r1l;
    assign ib.out_ready  = ordy;

    logic [1:0] grant_a, grant_b;
    logic       busy_a, busy_b;
`ifdef TX_SCHED_STATS_EN
    logic [15:0] f0a, f1a, pa, f0b, f1b, pb;
`endif

    tx_frame_scheduler #(.FRAME_BITS(FB), .GAP_CYCLES(2)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .bus   (ia),
        .grant (grant_a),
        .busy  (busy_a)
`ifdef TX_SCHED_STATS_EN
        ,
        .frames0_cnt (f0a),
        .frames1_cnt (f1a),
        .pad_cnt     (pa)
`endif
    );

    tx_frame_scheduler #(.FRAME_BITS(FB), .GAP_CYCLES(0)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .bus   (ib),
        .grant (grant_b),
        .busy  (busy_b)
`ifdef TX_SCHED_STATS_EN
        ,
        .frames0_cnt (f0b),
        .frames1_cnt (f1b),
        .pad_cnt     (pb)
`endif
    );

    logic [6:0] obs [2];
    assign obs[0] = {ia.out_valid, ia.out_data, ia.req0_ready,
                     ia.req1_ready, grant_a, busy_a};
    assign obs[1] = {ib.out_valid, ib.out_data, ib.req0_ready,
                     ib.req1_ready, grant_b, busy_b};

    // Model: owner number (0 none), bits moved, padding flag,
    // idle cycles still owed, and last owner (1 or 2).
    int m_owner [2] = '{0, 0};
    int m_n     [2] = '{0, 0};
    bit m_pad   [2] = '{0, 0};
    int m_gap   [2] = '{0, 0};
    int m_last  [2] = '{2, 2};
    int gapc    [2] = '{2, 0};

    bit         bits_a   [$];
    logic [1:0] hs_grant [$];
    logic [1:0] gseq     [$];
    int         runs     [$];
    logic [1:0] prev_ga  = 2'b00;
    int         idle_run = 0;

    always @(negedge clk) begin : model
        logic [6:0] exp;
        logic [1:0] g;
        int o;
        bit v, d, l, take;
        for (int k = 0; k < 2; k++) begin
            exp = '0;
            if (rst) begin
                m_owner[k] = 0;
                m_n[k]     = 0;
                m_pad[k]   = 0;
                m_gap[k]   = 0;
                m_last[k]  = 2;
            end else if (m_gap[k] > 0) begin
                exp = 7'b0000001;
                m_gap[k]--;
            end else if (m_owner[k] == 0) begin
                if (r0v || r1v) begin
                    if (r0v && r1v) o = 3 - m_last[k];
                    else            o = r0v ? 1 : 2;
                    m_owner[k] = o;
                    m_last[k]  = o;
                    m_n[k]     = 0;
                end
            end else begin
                o = m_owner[k];
                g = (o == 1) ? 2'b01 : 2'b10;
                l = 0;
                if (!m_pad[k]) begin
                    v = (o == 1) ? r0v : r1v;
                    d = (o == 1) ? r0d : r1d;
                    l = (o == 1) ? r0l : r1l;
                    exp = {v, d, (o == 1) && ordy,
                           (o == 2) && ordy, g, 1'b1};
                    take = v && ordy;
                end else begin
                    exp  = {4'b1000, g, 1'b1};
                    take = ordy;
                end
                if (take) begin
                    m_n[k]++;
                    if (m_n[k] == FB) begin
                        m_owner[k] = 0;
                        m_pad[k]   = 0;
                        m_n[k]     = 0;
                        m_gap[k]   = gapc[k];
                    end else if (l) begin
                        m_pad[k] = 1;
                    end
                end
            end
            checks++;
            if (obs[k] !== exp) begin
                errors++;
                $display("FAIL cycle dut%0d t=%0t got=%b expected=%b",
                         k, $time, obs[k], exp);
            end
        end
        if (!rst && ia.out_valid && ordy) begin
            bits_a.push_back(ia.out_data);
            hs_grant.push_back(grant_a);
        end
        if (!rst && grant_a != 2'b00 && prev_ga == 2'b00)
            gseq.push_back(grant_a);
        prev_ga = rst ? 2'b00 : grant_a;
        if (rst) begin
            idle_run = 0;
        end else if (!busy_b) begin
            idle_run++;
        end else begin
            if (idle_run > 0) runs.push_back(idle_run);
            idle_run = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic send_frame(input int who, input logic [15:0] bits,
                              input int n, input bit tog);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int t;
            if (who == 0) begin
                r0v = 1; r0d = bits[n-1-i]; r0l = (i == n - 1);
            end else begin
                r1v = 1; r1d = bits[n-1-i]; r1l = (i == n - 1);
            end
            acc = 0;
            t   = 0;
            while (!acc && t < 50) begin
                @(negedge clk); #1;
                acc = (who == 0) ? ia.req0_ready : ia.req1_ready;
                @(posedge clk); #1;
                if (tog) ordy = !ordy;
                t++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL send_timeout who=%0d bit=%0d", who, i);
            end
        end
        r0v = 0; r0l = 0; r1v = 0; r1l = 0;
    endtask

    task automatic wait_bits(input int n, input bit tog);
        int t = 0;
        forever begin
            @(negedge clk); #1;
            if (bits_a.size() >= n) break;
            if (t >= 60) begin
                checks++;
                errors++;
                $display("FAIL wait_bits got=%0d expected=%0d",
                         bits_a.size(), n);
                break;
            end
            @(posedge clk); #1;
            if (tog) ordy = !ordy;
            t++;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] bits8();
        logic [7:0] b = '0;
        for (int i = 0; i < 8 && i < bits_a.size(); i++)
            b = {b[6:0], bits_a[i]};
        return b;
    endfunction

    task automatic pulse_rst();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        logic [5:0] pat;
        logic [7:0] gv;
        int bad;

        repeat (3) @(posedge clk);
        #1 rst = 0;
        ordy = 1;

        // req0 alone, full frame, then two gap cycles
        bits_a.delete();
        hs_grant.delete();
        send_frame(0, 16'b10110011, 8, 0);
        pat = '0;
        repeat (3) begin
            @(negedge clk); #1;
            pat = {pat[3:0], busy_a, ia.out_valid};
        end
        @(posedge clk); #1;
        chk("gap_timing", 64'(pat), 64'b101000);
        chk("frame0_len", 64'(bits_a.size()), 64'd8);
        chk("frame0_bits", 64'(bits8()), 64'b10110011);
        bad = 0;
        foreach (hs_grant[i]) if (hs_grant[i] !== 2'b01) bad++;
        chk("frame0_grant", 64'(bad), 64'd0);

        // req1 early last with toggling out_ready -> padding
        repeat (3) @(posedge clk);
        #1 bits_a.delete();
        send_frame(1, 16'b111, 3, 1);
        wait_bits(8, 1);
        ordy = 1;
        chk("pad_len", 64'(bits_a.size()), 64'd8);
        chk("pad_bits", 64'(bits8()), 64'b11100000);
`ifdef TX_SCHED_STATS_EN
        chk("stats", {16'd0, f0a, f1a, pa},
            {16'd0, 16'd1, 16'd1, 16'd1});
`endif

        // both requesters streaming: round-robin and GAP=0 spacing
        repeat (3) @(posedge clk);
        #1 pulse_rst();
        gseq.delete();
        runs.delete();
        r0v = 1; r1v = 1; r0l = 0; r1l = 0;
        repeat (50) begin
            @(posedge clk); #1;
            r0d = 1'($urandom);
            r1d = 1'($urandom);
        end
        r0v = 0; r1v = 0;
        gv = '0;
        for (int i = 0; i < 4 && i < gseq.size(); i++)
            gv = {gv[5:0], gseq[i]};
        chk("rr_order", 64'(gv), 64'b01100110);
        bad = (runs.size() < 4) ? 1 : 0;
        foreach (runs[i]) if (runs[i] != 1) bad++;
        chk("gap0_idle", 64'(bad), 64'd0);

        // reset mid-frame at bit 4, then a clean frame
        pulse_rst();
        bits_a.delete();
        r0v = 1; r0d = 1;
        wait_bits(4, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk); #1;
        chk("rst_outputs",
            64'({ia.out_valid, grant_a, busy_a}), 64'd0);
        bits_a.delete();
        @(posedge clk); #1;
        wait_bits(8, 0);
        r0v = 0;
        @(negedge clk); #1;
        chk("rst_recount", 64'({busy_a, ia.out_valid}), 64'b10);
        @(posedge clk); #1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            r0v  = $urandom_range(0, 3) != 0;
            r1v  = $urandom_range(0, 3) != 0;
            r0d  = 1'($urandom);
            r1d  = 1'($urandom);
            r0l  = $urandom_range(0, 9) == 0;
            r1l  = $urandom_range(0, 9) == 0;
            ordy = $urandom_range(0, 3) != 0;
            rst  = $urandom_range(0, 399) == 0;
            @(posedge clk); #1;
        end
        rst = 0;
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_frame_scheduler.md
TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 64: bits per frame delivered to the BCH encoder input stream; legal range 2..4096.
REQ-002 SHALL have parameter GAP_CYCLES, default 4: idle cycles inserted after each frame; legal range 0..255.
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each: requester bit valid.
REQ-006 SHALL have ports req0_data / req1_data, input, 1 each: requester payload bit.
REQ-007 SHALL have ports req0_last / req1_last, input, 1 each: marks the requester's final bit of the current frame.
REQ-008 SHALL have ports req0_ready / req1_ready, output, 1 each: requester bit accepted.
REQ-009 SHALL have ports out_valid, out_data and out_ready (output, output, input; 1 bit each): AXI-Stream to the BCH encoder input.
REQ-010 SHALL have port grant, output, 2: one-hot current owner; 00 when no owner.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, SEND, PAD and GAP.
REQ-013 Arbitration in IDLE:
- If exactly one reqN_valid is high, that requester is granted.
- If both are high, the requester not granted last is granted (round-robin).
- The first tie after reset goes to req0.
- The transition to SEND happens on the next clock edge.
REQ-014 In SEND:
- out_valid = req_valid of the granted requester.
- out_data = req_data of the granted requester.
- req_ready of the granted requester = out_ready.
- The ungranted requester's ready is 0.
- Zero added latency (combinational pass-through).
REQ-015 The bit counter SHALL increment on each out_valid&&out_ready handshake; it counts 0..FRAME_BITS-1.
REQ-016 A handshake at count FRAME_BITS-1 SHALL end the frame and move to GAP, or to IDLE if GAP_CYCLES=0. This holds regardless of reqN_last.
REQ-017 Early last: a handshake with reqN_last=1 at count < FRAME_BITS-1 SHALL move to PAD.
REQ-018 In PAD:
- out_valid=1 and out_data=0.
- All req_ready are 0.
- PAD ends on the handshake that completes FRAME_BITS total bits.
REQ-019 In GAP:
- out_valid=0 and all ready signals are 0.
- The state lasts exactly GAP_CYCLES cycles, then moves to IDLE.
REQ-020 Requester stall in SEND (granted valid low) SHALL hold the state and the count. No timeout and no padding apply.
REQ-021 Downstream backpressure (out_ready=0) SHALL hold out_valid/out_data stable in PAD. In SEND, the held values are those of the requester.
REQ-022 grant SHALL be registered. It is set on entry to SEND, held through PAD, and cleared on entry to GAP or IDLE.
REQ-023 A requester raising valid during SEND, PAD or GAP of another frame SHALL wait; it is arbitrated only in IDLE.

Reset
REQ-024 While rst=1 and on the cycle after it is released, the outputs SHALL be:
- out_valid=0
- out_data=0
- req0_ready=0, req1_ready=0
- grant=00
- busy=0
REQ-025 Reset SHALL also put the state in IDLE, the counters at 0, and the last-grant pointer at req1 (so req0 wins the first tie).
REQ-026 Reset mid-frame SHALL abandon the partial frame with no padding. Downstream re-alignment is the responsibility of the TX path reset.

Configuration
REQ-027 With macro TX_SCHED_STATS_EN defined, the block SHALL add three outputs:
- frames0_cnt[15:0], frames1_cnt[15:0]: frames completed per requester.
- pad_cnt[15:0]: frames that included padding.
REQ-028 The statistics counters SHALL wrap at 0xFFFF and clear on reset.
REQ-029 Without the macro, these ports and counters SHALL be absent and the remaining behaviour is unchanged.

Structure
REQ-030 Package tx_sched_pkg SHALL hold:
- the state enumeration
- the bit-counter width constant, clog2(4096)
- the gap-counter width constant
REQ-031 The round-robin decision SHALL live in sub-module rr_arbiter_2. Inputs: two requests, the last-grant pointer and an enable. Output: one-hot grant.

Verification
REQ-032 FRAME_BITS=8, GAP=2: req0 sends 8 bits 10110011 with last on bit 7 -> out_data 10110011, then 2 idle cycles, then IDLE; grant=01 throughout.
REQ-033 FRAME_BITS=8: req1 sends 3 bits 111 with last on bit 2 -> out_data 11100000, pad_cnt=1 (stats build).
REQ-034 Both requesters valid continuously, 4 frames -> grant order 01,10,01,10.
REQ-035 out_ready toggles 1,0,1,0 during SEND and PAD -> no duplicated or dropped bits; out_data is stable while stalled; exactly 8 bits per frame.
REQ-036 rst pulsed for one cycle at bit 4 of a frame -> next cycle out_valid=0, grant=00, busy=0; a new frame then starts with count 0.
REQ-037 GAP_CYCLES=0 with both requesters valid -> frames are separated by exactly one IDLE arbitration cycle.
